// File: rtl/sc_fifo_ext_if.sv
// Request/status bundle between a FIFO user (master) and sc_fifo_ext (slave).
interface sc_fifo_ext_if #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned WORDS_AMOUNT = 8
);
    localparam int unsigned ADDR_WIDTH = $clog2(WORDS_AMOUNT);

    logic                  flush_i;
    logic                  wr_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  rd_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  rd_valid_o;
    logic [ADDR_WIDTH:0]   used_words_o;
    logic                  full_o;
    logic                  empty_o;
    logic                  almost_full_o;
    logic                  almost_empty_o;
    logic                  overflow_o;
    logic                  underflow_o;

    modport slave (
        input  flush_i, wr_i, wr_data_i, rd_i,
        output rd_data_o, rd_valid_o, used_words_o, full_o, empty_o,
               almost_full_o, almost_empty_o, overflow_o, underflow_o
    );

    modport master (
        output flush_i, wr_i, wr_data_i, rd_i,
        input  rd_data_o, rd_valid_o, used_words_o, full_o, empty_o,
               almost_full_o, almost_empty_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/sc_fifo_ext.sv
// Single-clock FIFO on an inferred dual-port RAM with registered status flags,
// optional show-ahead output stage, sticky overflow/underflow and synchronous flush.
module sc_fifo_ext #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned WORDS_AMOUNT = 8,
    parameter int unsigned SHOW_AHEAD   = 1,
    parameter int unsigned AFULL_LEVEL  = WORDS_AMOUNT - 2,
    parameter int unsigned AEMPTY_LEVEL = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    sc_fifo_ext_if.slave bus
);
    localparam int unsigned ADDR_WIDTH = $clog2(WORDS_AMOUNT);
    localparam int unsigned UW         = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(WORDS_AMOUNT - 1);
    localparam logic [UW-1:0]         FullCnt  = UW'(WORDS_AMOUNT);
    localparam bit                    ShowAhead = (SHOW_AHEAD != 0);

    logic [DATA_WIDTH-1:0] r_mem [WORDS_AMOUNT];
    logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
    logic [UW-1:0]         r_used;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_valid, r_empty, r_full, r_afull, r_aempty, r_ovf, r_udf;

    logic                  w_wr_acc, w_rd_acc, w_ram_rd, w_valid_d, w_empty_d;
    logic [UW-1:0]         w_used_d, w_ram_cnt;
    logic [ADDR_WIDTH-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;

    always_comb begin
        w_wr_acc     = bus.wr_i && !r_full && !bus.flush_i;
        w_rd_acc     = bus.rd_i && !r_empty && !bus.flush_i;
        w_wr_ptr_nxt = (r_wr_ptr == LastAddr) ? '0 : r_wr_ptr + ADDR_WIDTH'(1);
        w_rd_ptr_nxt = (r_rd_ptr == LastAddr) ? '0 : r_rd_ptr + ADDR_WIDTH'(1);
        // Words still in RAM, i.e. not yet moved into the show-ahead output stage
        w_ram_cnt    = r_used - UW'(r_valid);

        w_used_d = r_used;
        if (bus.flush_i) begin
            w_used_d = '0;
        end else if (w_wr_acc && !w_rd_acc) begin
            w_used_d = r_used + UW'(1);
        end else if (!w_wr_acc && w_rd_acc) begin
            w_used_d = r_used - UW'(1);
        end

        if (ShowAhead) begin
            w_ram_rd  = !bus.flush_i && (w_ram_cnt != '0) && (!r_valid || w_rd_acc);
            w_valid_d = !bus.flush_i && (w_ram_rd || (r_valid && !w_rd_acc));
            w_empty_d = !w_valid_d;
        end else begin
            w_ram_rd  = w_rd_acc;
            w_valid_d = w_rd_acc;
            w_empty_d = (w_used_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_used    <= '0;
            r_rd_data <= '0;
            r_valid   <= 1'b0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_afull   <= (AFULL_LEVEL == 0);
            r_aempty  <= 1'b1;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            r_used   <= w_used_d;
            r_valid  <= w_valid_d;
            r_empty  <= w_empty_d;
            r_full   <= (w_used_d == FullCnt);
            r_afull  <= (32'(w_used_d) >= AFULL_LEVEL);
            r_aempty <= (32'(w_used_d) <= AEMPTY_LEVEL);
            if (bus.flush_i) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_rd_data <= '0;
                r_ovf     <= 1'b0;
                r_udf     <= 1'b0;
            end else begin
                if (w_wr_acc) begin
                    r_wr_ptr <= w_wr_ptr_nxt;
                end
                if (w_ram_rd) begin
                    r_rd_ptr  <= w_rd_ptr_nxt;
                    r_rd_data <= r_mem[r_rd_ptr];
                end
                if (bus.wr_i && r_full) begin
                    r_ovf <= 1'b1;
                end
                if (bus.rd_i && r_empty) begin
                    r_udf <= 1'b1;
                end
            end
        end
    end

    assign bus.rd_data_o      = r_rd_data;
    assign bus.rd_valid_o     = r_valid;
    assign bus.used_words_o   = r_used;
    assign bus.full_o         = r_full;
    assign bus.empty_o        = r_empty;
    assign bus.almost_full_o  = r_afull;
    assign bus.almost_empty_o = r_aempty;
    assign bus.overflow_o     = r_ovf;
    assign bus.underflow_o    = r_udf;
endmodule

// File: tb/tb_sc_fifo_ext.sv
// Bench for sc_fifo_ext: a depth-5 show-ahead FIFO and a depth-8 registered-read FIFO
// driven with the same stimulus and compared each cycle against a queue-level model.
module tb_sc_fifo_ext;
    logic       clk_i   = 1'b0;
    logic       rst_i   = 1'b1;
    logic       s_flush = 1'b0;
    logic       s_wr    = 1'b0;
    logic       s_rd    = 1'b0;
    logic [7:0] s_wdata = '0;
    int         n_pass  = 0;
    int         n_total = 0;

    always #5 clk_i = ~clk_i;

    sc_fifo_ext_if #(.DATA_WIDTH(8), .WORDS_AMOUNT(5)) if0 ();
    sc_fifo_ext_if #(.DATA_WIDTH(8), .WORDS_AMOUNT(8)) if1 ();

    assign if0.flush_i   = s_flush;
    assign if0.wr_i      = s_wr;
    assign if0.rd_i      = s_rd;
    assign if0.wr_data_i = s_wdata;
    assign if1.flush_i   = s_flush;
    assign if1.wr_i      = s_wr;
    assign if1.rd_i      = s_rd;
    assign if1.wr_data_i = s_wdata;

    sc_fifo_ext #(.DATA_WIDTH(8), .WORDS_AMOUNT(5), .SHOW_AHEAD(1)) u_sa (
        .clk_i(clk_i), .rst_i(rst_i), .bus(if0)
    );
    sc_fifo_ext #(.DATA_WIDTH(8), .WORDS_AMOUNT(8), .SHOW_AHEAD(0), .AFULL_LEVEL(6),
                  .AEMPTY_LEVEL(2)) u_reg (
        .clk_i(clk_i), .rst_i(rst_i), .bus(if1)
    );

    // Reference model: a plain circular list of stored words per instance (0 = show-ahead).
    logic [7:0] m_buf [2][32];
    int         m_head [2];
    int         m_cnt [2];
    bit         m_ovf [2];
    bit         m_udf [2];
    bit         m_pres0;
    bit         m_valid1;
    logic [7:0] m_data1;

    function automatic int dep(int k);
        return (k == 0) ? 5 : 8;
    endfunction

    function automatic int afl(int k);
        return (k == 0) ? 3 : 6;
    endfunction

    function automatic bit m_empty(int k);
        return (k == 0) ? !m_pres0 : (m_cnt[1] == 0);
    endfunction

    task automatic chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_head[k] = 0;
            m_cnt[k]  = 0;
            m_ovf[k]  = 1'b0;
            m_udf[k]  = 1'b0;
        end
        m_pres0  = 1'b0;
        m_valid1 = 1'b0;
        m_data1  = '0;
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit         full, emp, wa, ra;
            int         old;
            logic [7:0] popped;
            full   = (m_cnt[k] == dep(k));
            emp    = m_empty(k);
            wa     = s_wr && !full && !s_flush;
            ra     = s_rd && !emp && !s_flush;
            old    = m_cnt[k];
            popped = m_buf[k][m_head[k]];
            if (s_flush) begin
                m_cnt[k]  = 0;
                m_head[k] = 0;
                m_ovf[k]  = 1'b0;
                m_udf[k]  = 1'b0;
                if (k == 0) m_pres0 = 1'b0;
                else begin
                    m_valid1 = 1'b0;
                    m_data1  = '0;
                end
            end else begin
                if (s_wr && full) m_ovf[k] = 1'b1;
                if (s_rd && emp) m_udf[k] = 1'b1;
                if (ra) begin
                    m_head[k] = (m_head[k] + 1) % 32;
                    m_cnt[k]--;
                end
                if (wa) begin
                    m_buf[k][(m_head[k] + m_cnt[k]) % 32] = s_wdata;
                    m_cnt[k]++;
                end
                // Head is shown next cycle only if a word stored before this edge remains
                if (k == 0) m_pres0 = (old - int'(ra)) > 0;
                else begin
                    m_valid1 = ra;
                    if (ra) m_data1 = popped;
                end
            end
        end
    endtask

    task automatic check_inst(int k, int used, bit empty, bit full, bit af, bit ae, bit ov,
                              bit un, bit vl, int data);
        string p;
        p = (k == 0) ? "sa" : "reg";
        chk({p, ".used"}, used, m_cnt[k]);
        chk({p, ".empty"}, empty, m_empty(k));
        chk({p, ".full"}, full, m_cnt[k] == dep(k));
        chk({p, ".afull"}, af, m_cnt[k] >= afl(k));
        chk({p, ".aempty"}, ae, m_cnt[k] <= 2);
        chk({p, ".ovf"}, ov, m_ovf[k]);
        chk({p, ".udf"}, un, m_udf[k]);
        if (k == 0) begin
            chk({p, ".valid"}, vl, m_pres0);
            if (m_pres0) chk({p, ".data"}, data, m_buf[0][m_head[0]]);
        end else begin
            chk({p, ".valid"}, vl, m_valid1);
            chk({p, ".data"}, data, m_data1);
        end
    endtask

    task automatic model_check();
        check_inst(0, if0.used_words_o, if0.empty_o, if0.full_o, if0.almost_full_o,
                   if0.almost_empty_o, if0.overflow_o, if0.underflow_o, if0.rd_valid_o,
                   if0.rd_data_o);
        check_inst(1, if1.used_words_o, if1.empty_o, if1.full_o, if1.almost_full_o,
                   if1.almost_empty_o, if1.overflow_o, if1.underflow_o, if1.rd_valid_o,
                   if1.rd_data_o);
    endtask

    task automatic step();
        @(posedge clk_i);
        if (rst_i) model_reset();
        else model_step();
        @(negedge clk_i);
        model_check();
    endtask

    task automatic drive(bit f, bit w, bit r, logic [7:0] d);
        s_flush = f;
        s_wr    = w;
        s_rd    = r;
        s_wdata = d;
    endtask

    task automatic reset_check(string tag);
        chk({tag, ".sa.used"}, if0.used_words_o, 0);
        chk({tag, ".sa.empty"}, if0.empty_o, 1);
        chk({tag, ".sa.aempty"}, if0.almost_empty_o, 1);
        chk({tag, ".sa.full"}, if0.full_o, 0);
        chk({tag, ".sa.afull"}, if0.almost_full_o, 0);
        chk({tag, ".sa.valid"}, if0.rd_valid_o, 0);
        chk({tag, ".sa.ovf"}, if0.overflow_o, 0);
        chk({tag, ".sa.udf"}, if0.underflow_o, 0);
        chk({tag, ".sa.data"}, if0.rd_data_o, 0);
        chk({tag, ".reg.used"}, if1.used_words_o, 0);
        chk({tag, ".reg.empty"}, if1.empty_o, 1);
        chk({tag, ".reg.aempty"}, if1.almost_empty_o, 1);
        chk({tag, ".reg.afull"}, if1.almost_full_o, 0);
        chk({tag, ".reg.valid"}, if1.rd_valid_o, 0);
        chk({tag, ".reg.data"}, if1.rd_data_o, 0);
    endtask

    typedef struct {
        bit         f, w, r;
        logic [7:0] d;
        int         used;
        bit         empty, full, ovf, udf;
        logic [7:0] data;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // Depth-5 show-ahead: fill past full, drain past empty, then flush
        tbl[0]  = '{0, 1, 0, 8'h01, 1, 1, 0, 0, 0, 8'h00};
        tbl[1]  = '{0, 1, 0, 8'h02, 2, 0, 0, 0, 0, 8'h01};
        tbl[2]  = '{0, 1, 0, 8'h03, 3, 0, 0, 0, 0, 8'h01};
        tbl[3]  = '{0, 1, 0, 8'h04, 4, 0, 0, 0, 0, 8'h01};
        tbl[4]  = '{0, 1, 0, 8'h05, 5, 0, 1, 0, 0, 8'h01};
        tbl[5]  = '{0, 1, 0, 8'h06, 5, 0, 1, 1, 0, 8'h01};
        tbl[6]  = '{0, 0, 1, 8'h00, 4, 0, 0, 1, 0, 8'h02};
        tbl[7]  = '{0, 0, 1, 8'h00, 3, 0, 0, 1, 0, 8'h03};
        tbl[8]  = '{0, 0, 1, 8'h00, 2, 0, 0, 1, 0, 8'h04};
        tbl[9]  = '{0, 0, 1, 8'h00, 1, 0, 0, 1, 0, 8'h05};
        tbl[10] = '{0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 8'h00};
        tbl[11] = '{0, 0, 1, 8'h00, 0, 1, 0, 1, 1, 8'h00};
        tbl[12] = '{1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00};

        model_reset();
        #12;
        reset_check("por");
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].f, tbl[i].w, tbl[i].r, tbl[i].d);
            step();
            chk($sformatf("tbl%0d.used", i), if0.used_words_o, tbl[i].used);
            chk($sformatf("tbl%0d.empty", i), if0.empty_o, tbl[i].empty);
            chk($sformatf("tbl%0d.full", i), if0.full_o, tbl[i].full);
            chk($sformatf("tbl%0d.ovf", i), if0.overflow_o, tbl[i].ovf);
            chk($sformatf("tbl%0d.udf", i), if0.underflow_o, tbl[i].udf);
            if (!tbl[i].empty) chk($sformatf("tbl%0d.data", i), if0.rd_data_o, tbl[i].data);
        end
        drive(0, 0, 0, 8'h00);
        step();

        // Twelve write/read pairs wrap the depth-5 pointers twice
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, 0, 8'(8'h40 + i));
            step();
            drive(0, 0, 0, 8'h00);
            step();
            chk($sformatf("wrap%0d.data", i), if0.rd_data_o, 8'h40 + i);
            chk($sformatf("wrap%0d.le1", i), int'(if0.used_words_o <= 1), 1);
            chk($sformatf("wrap%0d.nfull", i), if0.full_o, 0);
            drive(0, 0, 1, 8'h00);
            step();
            chk($sformatf("wrap%0d.empty", i), if0.empty_o, 1);
        end

        // Registered-read pulse and underflow
        drive(0, 1, 0, 8'hA5);
        step();
        drive(0, 0, 1, 8'h00);
        step();
        chk("rr.valid", if1.rd_valid_o, 1);
        chk("rr.data", if1.rd_data_o, 8'hA5);
        drive(0, 0, 0, 8'h00);
        step();
        chk("rr.pulse_end", if1.rd_valid_o, 0);
        chk("rr.hold", if1.rd_data_o, 8'hA5);
        drive(0, 0, 1, 8'h00);
        step();
        chk("rr.udf", if1.underflow_o, 1);
        chk("rr.udf_valid", if1.rd_valid_o, 0);

        // Almost-full / almost-empty thresholds on the depth-8 instance
        drive(1, 0, 0, 8'h00);
        step();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 8'(8'h60 + i));
            step();
        end
        chk("af.afull", if1.almost_full_o, 1);
        chk("af.aempty", if1.almost_empty_o, 0);
        chk("af.used", if1.used_words_o, 6);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 8'h00);
            step();
        end
        chk("ae.used", if1.used_words_o, 2);
        chk("ae.aempty", if1.almost_empty_o, 1);
        chk("ae.afull", if1.almost_full_o, 0);

        // Flush with a concurrent write while three words and overflow are present
        drive(1, 0, 0, 8'h00);
        step();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 8'(8'h70 + i));
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 8'h00);
            step();
        end
        chk("fl.pre_used", if0.used_words_o, 3);
        chk("fl.pre_ovf", if0.overflow_o, 1);
        drive(1, 1, 0, 8'hEE);
        step();
        chk("fl.used", if0.used_words_o, 0);
        chk("fl.empty", if0.empty_o, 1);
        chk("fl.ovf", if0.overflow_o, 0);
        drive(0, 0, 0, 8'h00);
        step();
        chk("fl.dropped", if0.used_words_o, 0);

        // Simultaneous write and read with exactly one word stored
        drive(0, 1, 0, 8'h77);
        step();
        drive(0, 0, 0, 8'h00);
        step();
        drive(0, 1, 1, 8'h88);
        chk("one.head", if0.rd_data_o, 8'h77);
        step();
        chk("one.sa_used", if0.used_words_o, 1);
        chk("one.reg_used", if1.used_words_o, 1);
        chk("one.reg_data", if1.rd_data_o, 8'h77);
        drive(0, 0, 0, 8'h00);
        step();
        chk("one.sa_new", if0.rd_data_o, 8'h88);

        // Asynchronous reset in the middle of a cycle with words stored
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 8'(8'h90 + i));
            step();
        end
        drive(0, 0, 0, 8'h00);
        chk("ar.pre_used", if0.used_words_o, 4);
        #2 rst_i = 1'b1;
        #1 reset_check("ar");
        step();
        rst_i = 1'b0;
        drive(0, 1, 0, 8'h3C);
        step();
        drive(0, 0, 0, 8'h00);
        step();
        chk("ar.sa_first", if0.rd_data_o, 8'h3C);
        drive(0, 0, 1, 8'h00);
        step();
        chk("ar.reg_first", if1.rd_data_o, 8'h3C);
        chk("ar.reg_valid", if1.rd_valid_o, 1);

        // Random traffic with alternating fill-biased and drain-biased phases
        for (int i = 0; i < 1200; i++) begin
            int wp;
            wp = (((i / 100) % 2) == 0) ? 8 : 3;
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 9) < wp,
                  $urandom_range(0, 9) < 5, 8'($urandom));
            step();
        end
        drive(0, 0, 0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sc_fifo_ext.md
SC_FIFO_EXT -- requirements
Module: sc_fifo_ext

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter WORDS_AMOUNT, default 8, storage depth in words; any integer >= 2, not limited to powers of two.
REQ-003 SHALL have parameter SHOW_AHEAD, default 1. 1 = head word presented without a read request; 0 = registered read, data one cycle after rd_i.
REQ-004 SHALL have parameter AFULL_LEVEL, default WORDS_AMOUNT-2, almost-full threshold in words.
REQ-005 SHALL have parameter AEMPTY_LEVEL, default 2, almost-empty threshold in words.
REQ-006 SHALL have derived parameter ADDR_WIDTH = $clog2(WORDS_AMOUNT).
REQ-007 Ports SHALL be as follows; reset is rst_i, asynchronous, active-high; clock is clk_i:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  synchronous clear
- wr_i  in  1  write request
- wr_data_i  in  DATA_WIDTH  write data
- rd_i  in  1  read request / pop
- rd_data_o  out  DATA_WIDTH  read data
- rd_valid_o  out  1  rd_data_o holds a valid word
- used_words_o  out  ADDR_WIDTH+1  words stored
- full_o  out  1  no free location
- empty_o  out  1  no readable word
- almost_full_o  out  1  used_words_o >= AFULL_LEVEL
- almost_empty_o  out  1  used_words_o <= AEMPTY_LEVEL
- overflow_o  out  1  sticky: write attempted while full
- underflow_o  out  1  sticky: read attempted while empty

Function
REQ-008 A write SHALL be accepted only when wr_i && !full_o && !flush_i. A read SHALL be accepted only when rd_i && !empty_o && !flush_i. Rejected requests SHALL leave storage, pointers and counts unchanged.
REQ-009 used_words_o SHALL behave as follows: +1 on accepted write only; -1 on accepted read only; unchanged on both or neither; range 0..WORDS_AMOUNT.
REQ-010 Write and read pointers SHALL wrap from WORDS_AMOUNT-1 to 0. Wrap SHALL be correct for non-power-of-two depths.
REQ-011 full_o SHALL be registered and SHALL be high exactly when used_words_o == WORDS_AMOUNT. A simultaneous write and read while full SHALL be treated as read only (write rejected).
REQ-012 SHOW_AHEAD=1 behaviour:
- empty_o SHALL deassert at the 2nd rising edge after a write is accepted into an empty FIFO.
- rd_data_o SHALL hold the oldest word whenever empty_o is low.
- An accepted rd_i SHALL present the next word on the following edge, or assert empty_o if none remains.
- rd_valid_o SHALL equal !empty_o.
- Sustained rd_i every cycle SHALL give one word per cycle with no bubbles while words remain.
REQ-013 SHOW_AHEAD=0 behaviour:
- empty_o SHALL be low exactly when used_words_o != 0, deasserting 1 cycle after the first accepted write.
- rd_data_o SHALL update 1 cycle after an accepted read.
- rd_valid_o SHALL pulse high for that cycle.
- rd_data_o SHALL hold its last value otherwise.
REQ-014 A simultaneous write and read on a FIFO holding exactly one word SHALL return that word, store the new word, and keep used_words_o at 1 in both modes.
REQ-015 almost_full_o and almost_empty_o SHALL be registered and SHALL be consistent with used_words_o in the same cycle.
REQ-016 overflow_o SHALL set on wr_i && full_o. underflow_o SHALL set on rd_i && empty_o. Both SHALL stay high until flush or reset.
REQ-017 When flush_i is high, the next edge SHALL clear pointers, used_words_o, full_o, the output stage, rd_valid_o, overflow_o and underflow_o, and SHALL set empty_o and almost_empty_o. wr_i and rd_i in the flush cycle SHALL be ignored.
REQ-018 Storage SHALL be an inferred simple dual-port RAM, one write port and one read port, same clock.

Reset
REQ-019 When rst_i is asserted, the block SHALL immediately (asynchronously) apply these values:
- used_words_o = 0
- empty_o = 1
- almost_empty_o = 1
- full_o = 0
- almost_full_o = 0 (1 if AFULL_LEVEL == 0)
- rd_valid_o = 0
- overflow_o = 0
- underflow_o = 0
- rd_data_o = 0
- pointers = 0
REQ-020 Reset asserted mid-transfer SHALL discard all stored words. The first write after release SHALL be returned as the first read.

Verification
REQ-021 WORDS_AMOUNT=5, SHOW_AHEAD=1: write 1..5 -> full_o=1 and used_words_o=5; 6th write -> overflow_o=1, data unchanged; read 5 -> 1..5 in order, then empty_o=1.
REQ-022 WORDS_AMOUNT=5: perform 12 write/read pairs so pointers wrap twice -> data returned in order, never full_o, used_words_o never >1.
REQ-023 SHOW_AHEAD=0: write 0xA5, then rd_i -> rd_valid_o pulses 1 cycle later with rd_data_o=0xA5; rd_i on empty -> underflow_o=1, rd_valid_o=0.
REQ-024 AFULL_LEVEL=6, AEMPTY_LEVEL=2, depth 8: fill to 6 -> almost_full_o=1 and almost_empty_o=0; drain to 2 -> almost_empty_o=1.
REQ-025 With 3 words stored and overflow_o set: assert flush_i with simultaneous wr_i -> next cycle used_words_o=0, empty_o=1, overflow_o=0, and the write is dropped.
REQ-026 With 4 words stored: assert rst_i asynchronously mid-cycle -> outputs take reset values immediately; after release, write 0x3C and read -> 0x3C.
